lsu_ctrl: RTL and testbench

Load/store controller between the execute stage and the `DataMem` data-memory block. Accepts one memory request at a time over a valid/ready handshake and checks alignment and opcode legality. Drives the memory read/write strobes for a parameterised access latency, so that a write reaches memory exactly once. Returns the sign/zero-extended load data, or an error flag, over a valid/ready response channel.

---
 rtl/lsu_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the execute stage and DataMem.
// Accepts one request at a time, screens it for alignment/opcode legality,
// strobes DataMem for LATENCY cycles (a store strobes only on the last one)
// and returns extended load data or an error over a response handshake.
// Every output comes straight from a flop, so no request or response input
// can reach an output combinationally.
module lsu_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_op,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  // MemOp encodings understood by DataMem
  localparam logic [2:0] OP_BYTE_S = 3'b000;
  localparam logic [2:0] OP_HALF_S = 3'b001;
  localparam logic [2:0] OP_WORD   = 3'b010;
  localparam logic [2:0] OP_BYTE_U = 3'b100;
  localparam logic [2:0] OP_HALF_U = 3'b101;

  // Counter reload value; LATENCY is restricted to 1..15 so four bits suffice
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [2:0]  op_reg;
  logic        wen_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic        ready_reg;
  logic        valid_reg;
  logic        rd_reg;
  logic        wr_reg;

  // Legality verdict for the request currently presented on req_*
  logic        req_illegal;

  // Flag misaligned accesses, reserved opcodes and unsigned-width stores
  always_comb begin
    req_illegal = 1'b0;
    case (req_op)
      OP_BYTE_S, OP_BYTE_U: req_illegal = 1'b0;
      OP_HALF_S, OP_HALF_U: req_illegal = req_addr[0];
      OP_WORD:              req_illegal = |req_addr[1:0];
      default:              req_illegal = 1'b1;
    endcase
    // Narrow stores have no signedness, so the unsigned forms are rejected
    if (req_wen && ((req_op == OP_BYTE_U) || (req_op == OP_HALF_U))) begin
      req_illegal = 1'b1;
    end
  end

  // Control FSM: state, latency counter, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 32'd0;
      op_reg    <= 3'd0;
      wen_reg   <= 1'b0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            // The latched request drives DataMem until the next acceptance
            addr_reg  <= req_addr;
            op_reg    <= req_op;
            wen_reg   <= req_wen;
            wdata_reg <= req_wdata;
            ready_reg <= 1'b0;
            if (req_illegal) begin
              // Rejected requests never touch memory
              state_reg <= RESP;
              valid_reg <= 1'b1;
              err_reg   <= 1'b1;
              rdata_reg <= 32'd0;
            end else begin
              state_reg <= ACCESS;
              cnt_reg   <= CNT_LOAD;
              rd_reg    <= ~req_wen;
              // With a single access cycle the write strobe is needed at once
              wr_reg    <= req_wen & (LATENCY == 1);
            end
          end
        end

        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= RESP;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            valid_reg <= 1'b1;
            err_reg   <= 1'b0;
            rdata_reg <= wen_reg ? 32'd0 : mem_rdata;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
            // DataMem writes whenever its enable is high, so strobe the
            // write only for the cycle in which the counter will read zero
            wr_reg  <= wen_reg & (cnt_reg == 4'd1);
          end
        end

        RESP: begin
          // Response data and error stay put after the handshake
          if (resp_ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          rd_reg    <= 1'b0;
          wr_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_reg;
  assign resp_valid = valid_reg;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign mem_addr   = addr_reg;
  assign mem_op     = op_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_rd     = rd_reg;
  assign mem_wr     = wr_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl. Three controllers run side by
// side (LATENCY 2, 4 and 1), each attached to its own small DataMem model
// covering 0x80000000..0x8000007F. Inputs are driven 1 ns after the rising
// edge (or on the falling edge); outputs are sampled on the falling edge.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic [2:0]  req_op     [3];
  logic        req_wen    [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic [31:0] mem_addr   [3];
  logic [2:0]  mem_op     [3];
  logic [31:0] mem_wdata  [3];
  logic        mem_rd     [3];
  logic        mem_wr     [3];
  logic [31:0] mem_rdata  [3];

  logic [31:0] mem [3][32];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] b2b_data [8] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h1234_5678, 32'h8765_4321,
                                32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'h7FFF_FFFF, 32'h8000_0000};

  for (genvar gi = 0; gi < 3; gi++) begin : gen_dut
    lsu_ctrl #(.LATENCY(gi == 0 ? 2 : (gi == 1 ? 4 : 1))) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[gi]),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_addr   (req_addr[gi]),
      .req_op     (req_op[gi]),
      .req_wen    (req_wen[gi]),
      .req_wdata  (req_wdata[gi]),
      .resp_valid (resp_valid[gi]),
      .resp_ready (resp_ready[gi]),
      .resp_rdata (resp_rdata[gi]),
      .resp_err   (resp_err[gi]),
      .mem_addr   (mem_addr[gi]),
      .mem_op     (mem_op[gi]),
      .mem_wdata  (mem_wdata[gi]),
      .mem_rd     (mem_rd[gi]),
      .mem_wr     (mem_wr[gi]),
      .mem_rdata  (mem_rdata[gi])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  // DataMem read path: little-endian lanes, extended per MemOp
  function automatic logic [31:0] model_read(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      3'b010:  return w;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      mem_rdata[k] = model_read(mem[k][mem_addr[k][6:2]], mem_addr[k][1:0], mem_op[k]);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_wr[k]) begin
        case (mem_op[k])
          3'b010:  mem[k][mem_addr[k][6:2]] <= mem_wdata[k];
          3'b001:  mem[k][mem_addr[k][6:2]][{mem_addr[k][1], 4'b0000} +: 16] <= mem_wdata[k][15:0];
          default: mem[k][mem_addr[k][6:2]][{mem_addr[k][1:0], 3'b000} +: 8] <= mem_wdata[k][7:0];
        endcase
      end
    end
  end

  // One complete request with resp_ready high, checked cycle by cycle
  task automatic run_req(input int k, input logic [31:0] addr, input logic [2:0] op,
                         input logic wen, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input string name);
    int lat;
    logic [3:0] flags;
    logic [3:0] exp_flags;
    lat = exp_err ? 0 : lat_of(k);
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_addr[k] = addr; req_op[k] = op;
    req_wen[k] = wen; req_wdata[k] = wdata; resp_ready[k] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready[k] !== 1'b1) begin
      n_bad++; $display("FAIL %s accept: req_ready=%b want 1", name, req_ready[k]);
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      flags = {req_ready[k], resp_valid[k], mem_rd[k], mem_wr[k]};
      if (c <= lat)           exp_flags = {2'b00, ~wen, wen & (c == lat)};
      else if (c == lat + 1)  exp_flags = 4'b0100;
      else                    exp_flags = 4'b1000;
      n_cmp++;
      if (flags !== exp_flags) begin
        n_bad++;
        $display("FAIL %s cycle %0d ready/valid/rd/wr: got %b want %b", name, c, flags, exp_flags);
      end
      if (c == lat + 1) begin
        n_cmp++;
        if ({resp_err[k], resp_rdata[k]} !== {exp_err, exp_rdata}) begin
          n_bad++;
          $display("FAIL %s resp: err=%b rdata=%h want err=%b rdata=%h",
                   name, resp_err[k], resp_rdata[k], exp_err, exp_rdata);
        end
        n_cmp++;
        if ({mem_addr[k], mem_op[k]} !== {addr, op}) begin
          n_bad++;
          $display("FAIL %s latch: mem_addr=%h mem_op=%b want %h %b", name, mem_addr[k], mem_op[k], addr, op);
        end
      end
    end
    n_cmp++;
    if ({resp_err[k], resp_rdata[k]} !== {exp_err, exp_rdata}) begin
      n_bad++;
      $display("FAIL %s hold_after_handshake: err=%b rdata=%h want err=%b rdata=%h",
               name, resp_err[k], resp_rdata[k], exp_err, exp_rdata);
    end
    $display("txn %s: inst=%0d addr=%h op=%b wen=%b -> rdata=%h err=%b",
             name, k, addr, op, wen, resp_rdata[k], resp_err[k]);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = 32'd0; req_op[k] = 3'd0;
      req_wen[k] = 1'b0; req_wdata[k] = 32'd0; resp_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({req_ready[k], resp_valid[k], resp_err[k], mem_rd[k], mem_wr[k]} !== 5'b10000) begin
        n_bad++;
        $display("FAIL reset_flags inst%0d: got %b want 10000", k,
                 {req_ready[k], resp_valid[k], resp_err[k], mem_rd[k], mem_wr[k]});
      end
      n_cmp++;
      if ({resp_rdata[k], mem_addr[k], mem_wdata[k], mem_op[k]} !== 99'd0) begin
        n_bad++;
        $display("FAIL reset_data inst%0d: rdata=%h addr=%h wdata=%h op=%b want all 0",
                 k, resp_rdata[k], mem_addr[k], mem_wdata[k], mem_op[k]);
      end
    end
    $display("txn reset: all instances checked");
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
  endtask

  task automatic test_word_load();
    run_req(0, 32'h8000_0000, 3'b010, 1'b1, 32'h0000_0000, 32'd0, 1'b0, "init_word0");
    run_req(0, 32'h8000_0004, 3'b010, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, "init_word1");
    run_req(0, 32'h8000_0004, 3'b010, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, "word_load");
  endtask

  task automatic test_byte_store();
    run_req(0, 32'h8000_0003, 3'b000, 1'b1, 32'h0000_00A5, 32'd0, 1'b0, "byte_store");
    run_req(0, 32'h8000_0003, 3'b000, 1'b0, 32'd0, 32'hFFFF_FFA5, 1'b0, "byte_load_s");
    run_req(0, 32'h8000_0003, 3'b100, 1'b0, 32'd0, 32'h0000_00A5, 1'b0, "byte_load_u");
    run_req(0, 32'h8000_0002, 3'b001, 1'b0, 32'd0, 32'hFFFF_A500, 1'b0, "half_load_s");
    run_req(0, 32'h8000_0002, 3'b101, 1'b0, 32'd0, 32'h0000_A500, 1'b0, "half_load_u");
  endtask

  task automatic test_errors();
    run_req(0, 32'h8000_0001, 3'b001, 1'b0, 32'd0, 32'd0, 1'b1, "err_half_misalign");
    run_req(0, 32'h8000_0002, 3'b010, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, "err_word_store_misalign");
    run_req(0, 32'h8000_0000, 3'b101, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, "err_store_op101");
    run_req(0, 32'h8000_0000, 3'b100, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, "err_store_op100");
    run_req(0, 32'h8000_0000, 3'b011, 1'b0, 32'd0, 32'd0, 1'b1, "err_op011");
    run_req(0, 32'h8000_0004, 3'b111, 1'b0, 32'd0, 32'd0, 1'b1, "err_op111");
    n_cmp++;
    if ({mem[0][0], mem[0][1]} !== {32'hA500_0000, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL err_no_write: mem0=%h mem1=%h want a5000000 deadbeef", mem[0][0], mem[0][1]);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0004; req_op[0] = 3'b010;
    req_wen[0] = 1'b0; resp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready[0], resp_valid[0], mem_rd[0], mem_wr[0], resp_rdata[0]} !== {4'b0100, 32'hDEAD_BEEF}) begin
        n_bad++;
        $display("FAIL stall cycle %0d: flags=%b rdata=%h want 0100 deadbeef", c,
                 {req_ready[0], resp_valid[0], mem_rd[0], mem_wr[0]}, resp_rdata[0]);
      end
      if (c == 5) begin
        req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_wdata[0] = 32'h1234_5678;
      end
      if (c == 6) begin
        req_valid[0] = 1'b0; req_wen[0] = 1'b0;
      end
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready[0], resp_valid[0]} !== 2'b01) begin
      n_bad++; $display("FAIL stall_release c8: ready/valid=%b want 01", {req_ready[0], resp_valid[0]});
    end
    @(negedge clk);
    n_cmp++;
    if ({req_ready[0], resp_valid[0], mem_rd[0], mem_wr[0], resp_rdata[0]} !== {4'b1000, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL stall_idle c9: flags=%b rdata=%h want 1000 deadbeef",
               {req_ready[0], resp_valid[0], mem_rd[0], mem_wr[0]}, resp_rdata[0]);
    end
    n_cmp++;
    if (mem[0][1] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL stall_ignored_req: mem1=%h want deadbeef", mem[0][1]);
    end
    $display("txn backpressure: rdata=%h held through stall", resp_rdata[0]);
  endtask

  task automatic test_reset_access();
    run_req(1, 32'h8000_0010, 3'b010, 1'b1, 32'h1111_1111, 32'd0, 1'b0, "rst_prestore");
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0010; req_op[1] = 3'b010;
    req_wen[1] = 1'b1; req_wdata[1] = 32'h2222_2222;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready[1], resp_valid[1], mem_rd[1], mem_wr[1]} !== 4'b0000) begin
        n_bad++; $display("FAIL rst_access cycle %0d: flags=%b want 0000", c,
                          {req_ready[1], resp_valid[1], mem_rd[1], mem_wr[1]});
      end
    end
    #1 rst_n[1] = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready[1], resp_valid[1], resp_err[1], mem_rd[1], mem_wr[1]} !== 5'b10000) begin
      n_bad++; $display("FAIL rst_async_flags: got %b want 10000",
                        {req_ready[1], resp_valid[1], resp_err[1], mem_rd[1], mem_wr[1]});
    end
    n_cmp++;
    if ({resp_rdata[1], mem_addr[1], mem_wdata[1], mem_op[1]} !== 99'd0) begin
      n_bad++; $display("FAIL rst_async_data: rdata=%h addr=%h wdata=%h op=%b want all 0",
                        resp_rdata[1], mem_addr[1], mem_wdata[1], mem_op[1]);
    end
    @(posedge clk); #2;
    rst_n[1] = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready[1], resp_valid[1], mem_rd[1], mem_wr[1]} !== 4'b1000) begin
        n_bad++; $display("FAIL rst_release cycle %0d: flags=%b want 1000", c,
                          {req_ready[1], resp_valid[1], mem_rd[1], mem_wr[1]});
      end
    end
    n_cmp++;
    if (mem[1][4] !== 32'h1111_1111) begin
      n_bad++; $display("FAIL rst_no_write: mem=%h want 11111111", mem[1][4]);
    end
    $display("txn reset_during_access: mem word=%h", mem[1][4]);
    run_req(1, 32'h8000_0010, 3'b010, 1'b0, 32'd0, 32'h1111_1111, 1'b0, "rst_reload");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_req(2, 32'h8000_0020 + 32'(4 * i), 3'b010, 1'b1, b2b_data[i], 32'd0, 1'b0, "b2b_fill");
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b1; req_addr[2] = 32'h8000_0020; req_op[2] = 3'b010;
    req_wen[2] = 1'b0; resp_ready[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready[2] !== 1'b1) begin
        n_bad++; $display("FAIL b2b[%0d] accept: req_ready=%b want 1", i, req_ready[2]);
      end
      @(posedge clk); #1;
      if (i < 7) req_addr[2] = 32'h8000_0020 + 32'(4 * (i + 1));
      else       req_valid[2] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({req_ready[2], resp_valid[2], mem_rd[2], mem_wr[2]} !== 4'b0010) begin
        n_bad++; $display("FAIL b2b[%0d] access: flags=%b want 0010", i,
                          {req_ready[2], resp_valid[2], mem_rd[2], mem_wr[2]});
      end
      @(negedge clk);
      n_cmp++;
      if ({resp_valid[2], resp_err[2], resp_rdata[2]} !== {2'b10, b2b_data[i]}) begin
        n_bad++; $display("FAIL b2b[%0d] resp: valid=%b err=%b rdata=%h want 1 0 %h", i,
                          resp_valid[2], resp_err[2], resp_rdata[2], b2b_data[i]);
      end
      $display("txn b2b[%0d]: rdata=%h", i, resp_rdata[2]);
    end
    @(negedge clk);
    n_cmp++;
    if ({req_ready[2], resp_valid[2]} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_end: ready/valid=%b want 10", {req_ready[2], resp_valid[2]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_errors();
    test_backpressure();
    test_reset_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
